// File: rtl/uc_sweep_pkg.sv
// Shared types and widths for the phase sweep sequencer.
package uc_sweep_pkg;

  localparam int unsigned DEF_PW       = 19;
  localparam int unsigned DEF_DW       = 16;
  localparam int unsigned DEF_NW       = 12;
  localparam int unsigned MAX_AVG_LOG2 = 15;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    ACCUM,
    EMIT
  } sweep_state_e;

  function automatic logic [3:0] clamp_avg(input logic [3:0] v);
    return (int'(v) > int'(MAX_AVG_LOG2)) ? 4'(MAX_AVG_LOG2) : v;
  endfunction

endpackage

// File: rtl/sweep_accum.sv
// I/Q accumulator with synchronous clear and arithmetic-shift averaging.
module sweep_accum
  import uc_sweep_pkg::*;
#(
  parameter int unsigned DW    = DEF_DW,
  parameter int unsigned ACC_W = 32
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          clr_i,
  input  logic          en_i,
  input  logic [DW-1:0] x_i,
  input  logic [DW-1:0] y_i,
  input  logic [3:0]    shift_i,
  output logic [DW-1:0] mean_x_o,
  output logic [DW-1:0] mean_y_o
);

  logic signed [ACC_W-1:0] acc_x_q, acc_x_d;
  logic signed [ACC_W-1:0] acc_y_q, acc_y_d;

  always_comb begin
    acc_x_d = acc_x_q;
    acc_y_d = acc_y_q;
    if (clr_i) begin
      acc_x_d = '0;
      acc_y_d = '0;
    end else if (en_i) begin
      acc_x_d = acc_x_q + ACC_W'($signed(x_i));
      acc_y_d = acc_y_q + ACC_W'($signed(y_i));
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      acc_x_q <= '0;
      acc_y_q <= '0;
    end else begin
      acc_x_q <= acc_x_d;
      acc_y_q <= acc_y_d;
    end
  end

  // Mean is taken from the next-state sum so the final strobe is included.
  assign mean_x_o = DW'(acc_x_d >>> shift_i);
  assign mean_y_o = DW'(acc_y_d >>> shift_i);

endmodule

// File: rtl/phase_sweep_ctrl.sv
// LO phase-increment sweep sequencer: retune, settle, average I/Q, emit result.
// Optional ce_down starvation timeout enabled by defining SWEEP_TIMEOUT_EN.
module phase_sweep_ctrl
  import uc_sweep_pkg::*;
#(
  parameter int unsigned PW    = DEF_PW,
  parameter int unsigned DW    = DEF_DW,
  parameter int unsigned NW    = DEF_NW,
  parameter int unsigned SW    = 16,
  parameter int unsigned ACC_W = 32
`ifdef SWEEP_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT_CYC = 4096
`endif
) (
  input  logic          sys_clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          abort,
  input  logic [PW-1:0] cfg_start_inc,
  input  logic [PW-1:0] cfg_step_inc,
  input  logic [NW-1:0] cfg_num_steps,
  input  logic [SW-1:0] cfg_settle,
  input  logic [3:0]    cfg_avg_log2,
  input  logic          ce_down,
  input  logic [DW-1:0] ds_x,
  input  logic [DW-1:0] ds_y,
  output logic [PW-1:0] phase_inc,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [NW-1:0] res_idx,
  output logic [PW-1:0] res_inc,
  output logic [DW-1:0] res_i,
  output logic [DW-1:0] res_q
);

  localparam int unsigned CW = (SW > 16) ? SW : 16;

  sweep_state_e  state_q;
  logic [PW-1:0] phase_inc_q, step_q, res_inc_q;
  logic [NW-1:0] idx_q, num_q, res_idx_q;
  logic [SW-1:0] settle_q;
  logic [3:0]    avg_q;
  logic [CW-1:0] cnt_q;
  logic          busy_q, done_q, res_valid_q;
  logic [DW-1:0] res_i_q, res_q_q, mean_i, mean_q;
  logic          acc_en, acc_clr, last_strobe, last_step, timeout;

  assign acc_en      = (state_q == ACCUM) && ce_down;
  assign acc_clr     = (state_q == IDLE) || ((state_q == EMIT) && res_ready);
  assign last_strobe = (cnt_q + CW'(1)) == (CW'(1) << avg_q);
  assign last_step   = (idx_q + NW'(1)) == num_q;

  sweep_accum #(.DW(DW), .ACC_W(ACC_W)) u_accum (
    .clk_i    (sys_clk),
    .rst_i    (rst_n),
    .clr_i    (acc_clr),
    .en_i     (acc_en),
    .x_i      (ds_x),
    .y_i      (ds_y),
    .shift_i  (avg_q),
    .mean_x_o (mean_i),
    .mean_y_o (mean_q)
  );

`ifdef SWEEP_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYC) + 1;
  logic [TW-1:0] tcnt_q;
  logic          err_q;

  assign timeout = ((state_q == SETTLE) || (state_q == ACCUM)) && !ce_down &&
                   (tcnt_q == TW'(TIMEOUT_CYC - 1));

  always_ff @(posedge sys_clk) begin
    if (rst_n) begin
      tcnt_q <= '0;
      err_q  <= 1'b0;
    end else begin
      if (((state_q == SETTLE) || (state_q == ACCUM)) && !ce_down) tcnt_q <= tcnt_q + TW'(1);
      else tcnt_q <= '0;
      if (state_q == IDLE && start && !abort) err_q <= 1'b0;
      else if (timeout) err_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  assign timeout = 1'b0;
  assign err     = 1'b0;
`endif

  always_ff @(posedge sys_clk) begin
    if (rst_n) begin
      state_q     <= IDLE;
      phase_inc_q <= '0;
      step_q      <= '0;
      num_q       <= '0;
      settle_q    <= '0;
      avg_q       <= '0;
      idx_q       <= '0;
      cnt_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      res_valid_q <= 1'b0;
      res_idx_q   <= '0;
      res_inc_q   <= '0;
      res_i_q     <= '0;
      res_q_q     <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start && !abort) begin
            step_q   <= cfg_step_inc;
            num_q    <= cfg_num_steps;
            settle_q <= cfg_settle;
            avg_q    <= clamp_avg(cfg_avg_log2);
            if (cfg_num_steps == '0) begin
              done_q <= 1'b1;
            end else begin
              state_q     <= SETTLE;
              phase_inc_q <= cfg_start_inc;
              busy_q      <= 1'b1;
              idx_q       <= '0;
              cnt_q       <= '0;
            end
          end
        end
        SETTLE: begin
          if (settle_q == '0) begin
            state_q <= ACCUM;
            cnt_q   <= '0;
          end else if (ce_down) begin
            if ((cnt_q + CW'(1)) == CW'(settle_q)) begin
              state_q <= ACCUM;
              cnt_q   <= '0;
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end
        end
        ACCUM: begin
          if (acc_en) begin
            if (last_strobe) begin
              state_q     <= EMIT;
              cnt_q       <= '0;
              res_valid_q <= 1'b1;
              res_idx_q   <= idx_q;
              res_inc_q   <= phase_inc_q;
              res_i_q     <= mean_i;
              res_q_q     <= mean_q;
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end
        end
        EMIT: begin
          if (res_ready) begin
            res_valid_q <= 1'b0;
            if (last_step) begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              state_q     <= SETTLE;
              phase_inc_q <= phase_inc_q + step_q;
              idx_q       <= idx_q + NW'(1);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
      // Abort and timeout override any transition above, including a handshake.
      if ((state_q != IDLE) && (abort || timeout)) begin
        state_q     <= IDLE;
        busy_q      <= 1'b0;
        res_valid_q <= 1'b0;
        done_q      <= 1'b1;
        cnt_q       <= '0;
      end
    end
  end

  assign phase_inc = phase_inc_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign res_valid = res_valid_q;
  assign res_idx   = res_idx_q;
  assign res_inc   = res_inc_q;
  assign res_i     = res_i_q;
  assign res_q     = res_q_q;

endmodule

// File: tb/tb_phase_sweep_ctrl.sv
// Directed scoreboard bench for phase_sweep_ctrl (timeout case built with SWEEP_TIMEOUT_EN).
`timescale 1ns/1ps
module tb_phase_sweep_ctrl;

  localparam int unsigned PW = 19;
  localparam int unsigned DW = 16;
  localparam int unsigned NW = 12;
  localparam int unsigned SW = 16;

  logic          clk = 1'b0;
  logic          rst, start, abort, ce_down, res_ready;
  logic [PW-1:0] cfg_start_inc, cfg_step_inc;
  logic [NW-1:0] cfg_num_steps;
  logic [SW-1:0] cfg_settle;
  logic [3:0]    cfg_avg_log2;
  logic [DW-1:0] ds_x, ds_y;
  logic [PW-1:0] phase_inc, res_inc;
  logic          busy, done, err, res_valid;
  logic [NW-1:0] res_idx;
  logic [DW-1:0] res_i, res_q;

  typedef struct packed {
    logic [NW-1:0] idx;
    logic [PW-1:0] inc;
    logic [DW-1:0] i;
    logic [DW-1:0] q;
  } res_t;

  res_t sb[$];
  int   tests = 0;
  int   fails = 0;
  int   done_cnt = 0;
  int   ce_phase = 0;
  logic ce_en = 1'b0;

  always #5 clk = ~clk;

`ifdef SWEEP_TIMEOUT_EN
  phase_sweep_ctrl #(.PW(PW), .DW(DW), .NW(NW), .SW(SW), .ACC_W(32), .TIMEOUT_CYC(64)) dut (
`else
  phase_sweep_ctrl #(.PW(PW), .DW(DW), .NW(NW), .SW(SW), .ACC_W(32)) dut (
`endif
    .sys_clk(clk), .rst_n(rst), .start(start), .abort(abort),
    .cfg_start_inc(cfg_start_inc), .cfg_step_inc(cfg_step_inc),
    .cfg_num_steps(cfg_num_steps), .cfg_settle(cfg_settle), .cfg_avg_log2(cfg_avg_log2),
    .ce_down(ce_down), .ds_x(ds_x), .ds_y(ds_y),
    .phase_inc(phase_inc), .busy(busy), .done(done), .err(err),
    .res_valid(res_valid), .res_ready(res_ready), .res_idx(res_idx),
    .res_inc(res_inc), .res_i(res_i), .res_q(res_q)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cfg(input logic [PW-1:0] s, input logic [PW-1:0] st, input logic [NW-1:0] n,
                         input logic [SW-1:0] se, input logic [3:0] a);
    cfg_start_inc = s;
    cfg_step_inc  = st;
    cfg_num_steps = n;
    cfg_settle    = se;
    cfg_avg_log2  = a;
  endtask

  task automatic expect_sweep(input logic [PW-1:0] s, input logic [PW-1:0] st, input int n,
                              input logic [DW-1:0] x, input logic [DW-1:0] y);
    res_t e;
    for (int k = 0; k < n; k++) begin
      e.idx = NW'(k);
      e.inc = PW'(int'(s) + k * int'(st));
      e.i   = x;
      e.q   = y;
      sb.push_back(e);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n = 0;
    @(negedge clk);
    while (done !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 64'(done), 64'(1));
  endtask

  // Decimator strobe: one cycle in four when enabled.
  initial begin
    ce_down = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      ce_phase = (ce_phase + 1) % 4;
      ce_down  = ce_en && (ce_phase == 0);
    end
  end

  always @(negedge clk) begin
    res_t e;
    if (done === 1'b1) done_cnt++;
    if (res_valid === 1'b1 && res_ready === 1'b1) begin
      chk("result_expected", 64'(sb.size() != 0), 64'(1));
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("res_idx", 64'(res_idx), 64'(e.idx));
        chk("res_inc", 64'(res_inc), 64'(e.inc));
        chk("res_i",   64'(res_i),   64'(e.i));
        chk("res_q",   64'(res_q),   64'(e.q));
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: observed no finish expected finish");
    fails++;
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    int n;
    rst = 1'b1; start = 1'b0; abort = 1'b0; res_ready = 1'b1;
    ds_x = '0; ds_y = '0;
    set_cfg('0, '0, '0, '0, '0);
    repeat (3) tick();
    @(negedge clk);
    chk("rst_phase_inc", 64'(phase_inc), 64'(0));
    chk("rst_busy",      64'(busy),      64'(0));
    chk("rst_done",      64'(done),      64'(0));
    chk("rst_err",       64'(err),       64'(0));
    chk("rst_res_valid", 64'(res_valid), 64'(0));
    chk("rst_res_i",     64'(res_i),     64'(0));
    tick();
    rst = 1'b0;
    tick();

    // Basic three-step sweep; cfg changes after start must not leak in.
    ds_x = 16'd100; ds_y = -16'sd50; ce_en = 1'b1;
    set_cfg(19'd80652, 19'd1000, 12'd3, 16'd2, 4'd2);
    expect_sweep(19'd80652, 19'd1000, 3, 16'd100, -16'sd50);
    d0 = done_cnt;
    pulse_start();
    set_cfg(19'd0, 19'd5, 12'd9, 16'd0, 4'd0);
    @(negedge clk);
    chk("t1_busy",      64'(busy),      64'(1));
    chk("t1_phase_inc", 64'(phase_inc), 64'(80652));
    wait_done("t1_done", 600);
    chk("t1_phase_hold", 64'(phase_inc), 64'(82652));
    chk("t1_busy_end",   64'(busy),      64'(0));
    repeat (3) tick();
    @(negedge clk);
    chk("t1_done_count", 64'(done_cnt - d0), 64'(1));
    chk("t1_all_results", 64'(sb.size()), 64'(0));

    // Phase increment wrap modulo 2^19.
    set_cfg(19'd524000, 19'd1000, 12'd2, 16'd2, 4'd2);
    expect_sweep(19'd524000, 19'd1000, 2, 16'd100, -16'sd50);
    tick();
    pulse_start();
    wait_done("wrap_done", 600);
    chk("wrap_phase_inc", 64'(phase_inc), 64'(712));
    chk("wrap_results", 64'(sb.size()), 64'(0));

    // Back-pressure: result must hold while res_ready is low.
    res_ready = 1'b0; ds_x = 16'd7; ds_y = -16'sd5;
    set_cfg(19'd1234, 19'd10, 12'd1, 16'd1, 4'd1);
    expect_sweep(19'd1234, 19'd10, 1, 16'd7, -16'sd5);
    tick();
    pulse_start();
    n = 0;
    @(negedge clk);
    while (res_valid !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("hold_valid_seen", 64'(res_valid), 64'(1));
    ds_x = 16'd1000; ds_y = 16'd1000;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (c % 5 == 4) begin
        chk("hold_valid",     64'(res_valid), 64'(1));
        chk("hold_res_i",     64'(res_i),     64'(7));
        chk("hold_res_q",     64'(res_q),     64'(16'hFFFB));
        chk("hold_phase_inc", 64'(phase_inc), 64'(1234));
      end
    end
    tick();
    res_ready = 1'b1;
    wait_done("hold_done", 50);
    chk("hold_results", 64'(sb.size()), 64'(0));

    // Settle 0 and single-sample average.
    ds_x = -16'sd300; ds_y = 16'd42;
    set_cfg(19'd300, 19'd7, 12'd2, 16'd0, 4'd0);
    expect_sweep(19'd300, 19'd7, 2, -16'sd300, 16'd42);
    tick();
    pulse_start();
    wait_done("min_done", 200);
    chk("min_results", 64'(sb.size()), 64'(0));

    // Abort in ACCUM.
    ds_x = 16'd5; ds_y = 16'd5;
    set_cfg(19'd5000, 19'd1, 12'd3, 16'd1, 4'd3);
    tick();
    pulse_start();
    repeat (12) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    @(negedge clk);
    chk("abort_busy",      64'(busy),      64'(0));
    chk("abort_done",      64'(done),      64'(1));
    chk("abort_valid",     64'(res_valid), 64'(0));
    chk("abort_phase_inc", 64'(phase_inc), 64'(5000));
    tick();
    @(negedge clk);
    chk("abort_done_pulse", 64'(done), 64'(0));

    // Start and abort together in IDLE: nothing happens.
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    @(negedge clk);
    chk("startabort_busy", 64'(busy), 64'(0));
    chk("startabort_done", 64'(done), 64'(0));

    // Empty sweep.
    set_cfg(19'd777, 19'd1, 12'd0, 16'd1, 4'd1);
    tick();
    d0 = done_cnt;
    pulse_start();
    @(negedge clk);
    chk("empty_done",      64'(done),      64'(1));
    chk("empty_busy",      64'(busy),      64'(0));
    chk("empty_phase_inc", 64'(phase_inc), 64'(5000));
    tick();
    @(negedge clk);
    chk("empty_done_pulse", 64'(done_cnt - d0), 64'(1));
    chk("empty_busy_after", 64'(busy),          64'(0));

    // Reset mid-sweep.
    set_cfg(19'd900, 19'd1, 12'd2, 16'd1, 4'd3);
    tick();
    pulse_start();
    repeat (6) tick();
    rst = 1'b1;
    tick();
    @(negedge clk);
    chk("midrst_busy",      64'(busy),      64'(0));
    chk("midrst_phase_inc", 64'(phase_inc), 64'(0));
    chk("midrst_valid",     64'(res_valid), 64'(0));
    rst = 1'b0;
    tick();

`ifdef SWEEP_TIMEOUT_EN
    // Starved decimator: timeout after 64 cycles in SETTLE.
    ce_en = 1'b0;
    set_cfg(19'd40, 19'd1, 12'd1, 16'd2, 4'd0);
    tick();
    pulse_start();
    n = 0;
    @(negedge clk);
    while (done !== 1'b1 && n < 200) begin
      n++;
      @(negedge clk);
    end
    chk("to_cycles", 64'(n),    64'(64));
    chk("to_done",   64'(done), 64'(1));
    chk("to_err",    64'(err),  64'(1));
    chk("to_busy",   64'(busy), 64'(0));
    ce_en = 1'b1;
    set_cfg(19'd40, 19'd1, 12'd0, 16'd2, 4'd0);
    tick();
    pulse_start();
    @(negedge clk);
    chk("to_err_clear", 64'(err), 64'(0));
`else
    chk("err_tied_low", 64'(err), 64'(0));
`endif

    repeat (4) tick();
    chk("sb_empty_end", 64'(sb.size()), 64'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
